// File: rtl/peripheral_mpi_pkg.sv
// Shared types and defaults for the MPI NoC store-and-forward packet buffer.
package peripheral_mpi_pkg;

   localparam int FLIT_WIDTH_DEF = 32;

   typedef enum logic {
      ACCEPT  = 1'b0,
      DISCARD = 1'b1
   } buf_state_t;

   typedef struct packed {
      logic                      last;
      logic [FLIT_WIDTH_DEF-1:0] data;
   } flit_t;

   // Length counter must hold MAX_PKT_LEN+1 to detect the overflowing flit.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 2);
   endfunction

endpackage

// File: rtl/peripheral_mpi_flit_ram.sv
// Flit storage: one synchronous write port, one asynchronous (fall-through) read port.
module peripheral_mpi_flit_ram #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_mpi_noc_pkt_buffer.sv
// Store-and-forward packet buffer: packets become visible only once complete;
// oversize packets are rolled back and the rest of them swallowed.
module peripheral_mpi_noc_pkt_buffer
   import peripheral_mpi_pkg::*;
#(
   parameter int FLIT_WIDTH  = FLIT_WIDTH_DEF,
   parameter int DEPTH       = 16,
   parameter int MAX_PKT_LEN = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FLIT_WIDTH-1:0]     noc_in_flit,
   input  logic                      noc_in_last,
   input  logic                      noc_in_valid,
   output logic                      noc_in_ready,
   output logic [FLIT_WIDTH-1:0]     noc_out_flit,
   output logic                      noc_out_last,
   output logic                      noc_out_valid,
   input  logic                      noc_out_ready,
   output logic [$clog2(DEPTH):0]    pkt_count,
   output logic                      drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LEN_W = len_width(MAX_PKT_LEN);

   localparam logic [PTR_W:0]   PTR_ONE   = 1;
   localparam logic [PTR_W:0]   PTR_DEPTH = DEPTH;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [LEN_W-1:0] LEN_ONE   = 1;
   localparam logic [LEN_W-1:0] LEN_MAX   = MAX_PKT_LEN;

   buf_state_t       state_reg, state_next;
   logic [PTR_W:0]   rd_ptr_reg;
   logic [PTR_W:0]   wr_commit_reg;
   logic [PTR_W:0]   wr_spec_reg;
   logic [CNT_W-1:0] pkt_count_reg;
   logic [LEN_W-1:0] pkt_len_reg;
   logic             drop_reg;

   logic [PTR_W:0]   fill_spec;
   logic             full;
   logic [LEN_W-1:0] pkt_len_inc;
   logic             oversize;
   logic             in_fire;
   logic             out_fire;
   logic             accept_fire;
   logic             wr_en;
   logic             commit;
   logic             rollback;
   logic             pop_last;
   logic [FLIT_WIDTH:0] ram_wdata;
   logic [FLIT_WIDTH:0] ram_rdata;

   assign fill_spec   = wr_spec_reg - rd_ptr_reg;
   assign full        = (fill_spec == PTR_DEPTH);
   assign pkt_len_inc = pkt_len_reg + LEN_ONE;
   assign oversize    = (pkt_len_inc > LEN_MAX);

   assign in_fire     = noc_in_valid && noc_in_ready;
   assign out_fire    = noc_out_valid && noc_out_ready;
   assign accept_fire = in_fire && (state_reg == ACCEPT);
   assign wr_en       = accept_fire && !oversize;
   assign commit      = wr_en && noc_in_last;
   assign rollback    = accept_fire && oversize;
   assign pop_last    = out_fire && ram_rdata[FLIT_WIDTH];

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ACCEPT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ACCEPT: begin
            if (rollback && !noc_in_last) begin
               state_next = DISCARD;
            end
         end
         DISCARD: begin
            if (in_fire && noc_in_last) begin
               state_next = ACCEPT;
            end
         end
         default: state_next = ACCEPT;
      endcase
   end

   always_comb begin
      noc_in_ready = 1'b1;
      if (state_reg == ACCEPT) begin
         noc_in_ready = !full;
      end
   end

   // ---------------- Pointers and counters ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_reg    <= '0;
         wr_commit_reg <= '0;
         wr_spec_reg   <= '0;
         pkt_count_reg <= '0;
         pkt_len_reg   <= '0;
         drop_reg      <= 1'b0;
      end else begin
         drop_reg <= rollback;

         // Rollback only rewinds the speculative pointer; a concurrent pop is unaffected.
         if (rollback) begin
            wr_spec_reg <= wr_commit_reg;
         end else if (wr_en) begin
            wr_spec_reg <= wr_spec_reg + PTR_ONE;
         end

         if (commit) begin
            wr_commit_reg <= wr_spec_reg + PTR_ONE;
         end

         if (commit || rollback) begin
            pkt_len_reg <= '0;
         end else if (wr_en) begin
            pkt_len_reg <= pkt_len_inc;
         end

         if (out_fire) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end

         case ({commit, pop_last})
            2'b10:   pkt_count_reg <= pkt_count_reg + CNT_ONE;
            2'b01:   pkt_count_reg <= pkt_count_reg - CNT_ONE;
            default: pkt_count_reg <= pkt_count_reg;
         endcase
      end
   end

   // ---------------- Storage ----------------
   assign ram_wdata = {noc_in_last, noc_in_flit};

   peripheral_mpi_flit_ram #(
      .WIDTH (FLIT_WIDTH + 1),
      .DEPTH (DEPTH)
   ) u_flit_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_spec_reg[PTR_W-1:0]),
      .wdata (ram_wdata),
      .raddr (rd_ptr_reg[PTR_W-1:0]),
      .rdata (ram_rdata)
   );

   // pkt_count only counts committed packets, so the head is never uncommitted data.
   assign noc_out_valid = (pkt_count_reg != '0);
   assign noc_out_flit  = ram_rdata[FLIT_WIDTH-1:0];
   assign noc_out_last  = noc_out_valid && ram_rdata[FLIT_WIDTH];
   assign pkt_count     = pkt_count_reg;
   assign drop          = drop_reg;

endmodule

// File: tb/tb_peripheral_mpi_noc_pkt_buffer.sv
// Directed and randomly throttled checks of the store-and-forward packet buffer.
module tb_peripheral_mpi_noc_pkt_buffer;

   localparam int FW = 32;
   localparam int D  = 16;
   localparam int M  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] noc_in_flit;
   logic          noc_in_last;
   logic          noc_in_valid;
   logic          noc_in_ready;
   logic [FW-1:0] noc_out_flit;
   logic          noc_out_last;
   logic          noc_out_valid;
   logic          noc_out_ready;
   logic [$clog2(D):0] pkt_count;
   logic          drop;

   int checks = 0;
   int errors = 0;

   peripheral_mpi_noc_pkt_buffer #(
      .FLIT_WIDTH  (FW),
      .DEPTH       (D),
      .MAX_PKT_LEN (M)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .noc_in_flit   (noc_in_flit),
      .noc_in_last   (noc_in_last),
      .noc_in_valid  (noc_in_valid),
      .noc_in_ready  (noc_in_ready),
      .noc_out_flit  (noc_out_flit),
      .noc_out_last  (noc_out_last),
      .noc_out_valid (noc_out_valid),
      .noc_out_ready (noc_out_ready),
      .pkt_count     (pkt_count),
      .drop          (drop)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs at the falling edge, then settle so outputs can be sampled.
   task automatic cyc(input logic v, input logic [FW-1:0] d, input logic l, input logic ordy);
      @(negedge clk);
      noc_in_valid  = v;
      noc_in_flit   = d;
      noc_in_last   = l;
      noc_out_ready = ordy;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      noc_in_valid = 1'b0;
      noc_out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", noc_in_ready); end
      checks++; if (noc_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", noc_out_valid); end
      checks++; if (noc_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", noc_out_last); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop); end
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
      $display("test_reset done");
   endtask

   task automatic test_single_packet();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'hA0 + i, (i == 2), 1'b1);
         checks++; if (noc_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid[%0d]: got %b expected 0", i, noc_out_valid); end
         checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready[%0d]: got %b expected 1", i, noc_in_ready); end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1);
         $display("single out: valid=%b flit=%h last=%b count=%0d", noc_out_valid, noc_out_flit, noc_out_last, pkt_count);
         checks++; if (noc_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, noc_out_valid); end
         checks++; if (noc_out_flit !== 32'hA0 + i) begin errors++; $display("FAIL single_flit[%0d]: got %h expected %h", i, noc_out_flit, 32'hA0 + i); end
         checks++; if (noc_out_last !== (i == 2)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", i, noc_out_last, (i == 2)); end
         checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL single_count[%0d]: got %0d expected 1", i, pkt_count); end
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
      checks++; if (noc_out_valid !== 1'b0) begin errors++; $display("FAIL single_drained_valid: got %b expected 0", noc_out_valid); end
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL single_drained_count: got %0d expected 0", pkt_count); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 32'h200 + i, (i % 4 == 3), 1'b0);
         checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, noc_in_ready); end
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++; if (pkt_count !== 5'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", pkt_count); end
      checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_held: got %b expected 1", noc_in_ready); end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1);
         $display("b2b out: flit=%h last=%b", noc_out_flit, noc_out_last);
         checks++; if (noc_out_valid !== 1'b1 || noc_out_flit !== 32'h200 + i) begin errors++; $display("FAIL b2b_flit[%0d]: got v=%b %h expected v=1 %h", i, noc_out_valid, noc_out_flit, 32'h200 + i); end
         checks++; if (noc_out_last !== (i % 4 == 3)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, noc_out_last, (i % 4 == 3)); end
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", pkt_count); end
   endtask

   task automatic test_oversize();
      int drops = 0;
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b1, 32'h300 + i, (i == 9), 1'b1);
         checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL over_in_ready[%0d]: got %b expected 1", i, noc_in_ready); end
         drops += int'(drop);
         seen  += int'(noc_out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1);
         drops += int'(drop);
         seen  += int'(noc_out_valid);
      end
      $display("oversize: drop pulses=%0d valid cycles=%0d", drops, seen);
      checks++; if (drops != 1) begin errors++; $display("FAIL over_drop_count: got %0d expected 1", drops); end
      checks++; if (seen != 0) begin errors++; $display("FAIL over_out_valid: got %0d cycles expected 0", seen); end
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL over_count: got %0d expected 0", pkt_count); end
      cyc(1'b1, 32'h400, 1'b0, 1'b1);
      cyc(1'b1, 32'h401, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1);
         checks++; if (noc_out_valid !== 1'b1 || noc_out_flit !== 32'h400 + i || noc_out_last !== (i == 1)) begin
            errors++; $display("FAIL over_follow[%0d]: got v=%b %h l=%b expected v=1 %h l=%b", i, noc_out_valid, noc_out_flit, noc_out_last, 32'h400 + i, (i == 1));
         end
      end
      cyc(1'b0, '0, 1'b0, 1'b1);
      checks++; if (noc_out_valid !== 1'b0) begin errors++; $display("FAIL over_follow_end: got %b expected 0", noc_out_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 32'h500 + i, (i % 4 == 3), 1'b0);
         checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b expected 1", i, noc_in_ready); end
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++; if (noc_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", noc_in_ready); end
      checks++; if (pkt_count !== 5'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", pkt_count); end
      // Offer a flit while popping at full: the write must stay blocked this cycle.
      cyc(1'b1, 32'h5FF, 1'b1, 1'b1);
      checks++; if (noc_out_flit !== 32'h500) begin errors++; $display("FAIL full_pop_flit: got %h expected 500", noc_out_flit); end
      checks++; if (noc_in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b expected 0", noc_in_ready); end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 1", noc_in_ready); end
      checks++; if (pkt_count !== 5'd4) begin errors++; $display("FAIL full_after_pop_count: got %0d expected 4", pkt_count); end
      checks++; if (noc_out_flit !== 32'h501) begin errors++; $display("FAIL full_next_head: got %h expected 501", noc_out_flit); end
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      cyc(1'b1, 32'h600, 1'b0, 1'b0);
      cyc(1'b1, 32'h601, 1'b1, 1'b0);
      cyc(1'b1, 32'h602, 1'b0, 1'b0);
      cyc(1'b1, 32'h603, 1'b0, 1'b0);
      checks++; if (pkt_count !== 5'd1) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 1", pkt_count); end
      @(negedge clk);
      rst = 1'b1;
      noc_in_valid = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", pkt_count); end
      checks++; if (noc_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", noc_out_valid); end
      checks++; if (noc_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", noc_in_ready); end
      cyc(1'b1, 32'h700, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      checks++; if (noc_out_valid !== 1'b1 || noc_out_flit !== 32'h700 || noc_out_last !== 1'b1) begin
         errors++; $display("FAIL midrst_first: got v=%b %h l=%b expected v=1 700 l=1", noc_out_valid, noc_out_flit, noc_out_last);
      end
      cyc(1'b0, '0, 1'b0, 1'b0);
      checks++; if (pkt_count !== 5'd0) begin errors++; $display("FAIL midrst_drained: got %0d expected 0", pkt_count); end
   endtask

   task automatic test_random();
      logic [FW:0] exp_q[$];
      int sent_pkts = 0;
      int rcv_pkts  = 0;
      int drops     = 0;
      int flits     = 0;
      do_reset();
      fork
         begin : producer
            int   rem  = 0;
            int   guard = 0;
            logic hold = 1'b0;
            logic [FW-1:0] seq = 32'h1000;
            while (sent_pkts < 1000 && guard < 60000) begin
               @(negedge clk);
               guard++;
               if (!hold) begin
                  if ($urandom_range(0, 3) != 0) begin
                     if (rem == 0) rem = $urandom_range(1, M);
                     noc_in_flit  = seq;
                     noc_in_last  = (rem == 1);
                     noc_in_valid = 1'b1;
                     hold = 1'b1;
                  end else begin
                     noc_in_valid = 1'b0;
                  end
               end
               #1;
               if (noc_in_valid && noc_in_ready) begin
                  exp_q.push_back({noc_in_last, noc_in_flit});
                  seq++;
                  rem--;
                  if (noc_in_last) sent_pkts++;
                  hold = 1'b0;
               end
            end
            @(negedge clk);
            noc_in_valid = 1'b0;
         end
         begin : consumer
            int guard = 0;
            logic [FW:0] exp;
            while (rcv_pkts < 1000 && guard < 60000) begin
               @(negedge clk);
               guard++;
               noc_out_ready = ($urandom_range(0, 1) == 1);
               #1;
               if (drop) drops++;
               if (noc_out_valid && noc_out_ready) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++; $display("FAIL rand_unexpected: got %h with empty scoreboard", noc_out_flit);
                  end else begin
                     exp = exp_q.pop_front();
                     flits++;
                     if ({noc_out_last, noc_out_flit} !== exp) begin
                        errors++; $display("FAIL rand_flit: got l=%b %h expected l=%b %h", noc_out_last, noc_out_flit, exp[FW], exp[FW-1:0]);
                     end
                  end
                  if (noc_out_last) rcv_pkts++;
               end
            end
            noc_out_ready = 1'b0;
         end
      join
      $display("random: %0d packets sent, %0d received, %0d flits checked", sent_pkts, rcv_pkts, flits);
      checks++; if (rcv_pkts != 1000) begin errors++; $display("FAIL rand_timeout: got %0d packets expected 1000", rcv_pkts); end
      checks++; if (drops != 0) begin errors++; $display("FAIL rand_drop: got %0d pulses expected 0", drops); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d flits expected 0", exp_q.size()); end
   endtask

   initial begin
      rst = 1'b1;
      noc_in_flit = '0;
      noc_in_last = 1'b0;
      noc_in_valid = 1'b0;
      noc_out_ready = 1'b0;
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_oversize();
      test_full();
      test_reset_mid_packet();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
